// File: rtl/calc_pkg.sv
// Shared types and helpers for the calc_decimal arbiter and its picker.
//   arb_state_e     : arbiter FSM states (ZERO is used only with CALC_ARB_DIVZERO_EN)
//   calc_idx_width  : bit width of a requester index
//   CALC_ERR_ONES   : all-ones source for the divide-by-zero result
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ZERO = 2'd2
    } arb_state_e;

    // Index width for num_req requesters; never narrower than one bit.
    function automatic int unsigned calc_idx_width(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    localparam logic [63:0] CALC_ERR_ONES = '1;

endpackage

// File: rtl/calc_decimal_arbiter_rr_pick.sv
// Combinational round-robin priority picker.
// Scans upward from (last_grant_i + 1) mod P_NUM_REQ, wrapping, and returns
// the first set request.
//   req_i         : per-requester request level
//   last_grant_i  : index granted most recently
//   grant_valid_o : some request is set
//   grant_idx_o   : chosen requester index
module rr_pick
    import calc_pkg::*;
#(
    parameter int unsigned P_NUM_REQ = 4
) (
    input  logic [P_NUM_REQ-1:0]                 req_i,
    input  logic [calc_idx_width(P_NUM_REQ)-1:0] last_grant_i,
    output logic                                 grant_valid_o,
    output logic [calc_idx_width(P_NUM_REQ)-1:0] grant_idx_o
);

    localparam int unsigned IW = calc_idx_width(P_NUM_REQ);

    int unsigned cand;

    // First candidate is the one just after the last grant; the last grant itself is checked last.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        cand          = 0;
        for (int unsigned k = 1; k <= P_NUM_REQ; k++) begin
            cand = (32'(last_grant_i) + k) % P_NUM_REQ;
            if (!grant_valid_o && req_i[IW'(cand)]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/calc_decimal_arbiter.sv
// Round-robin arbiter sharing one calc_decimal divider between P_NUM_REQ requesters.
// Latches the granted operands, pulses dec_start, waits for dec_done and routes
// the quotient back to the owning requester.
// Optional feature macro: CALC_ARB_DIVZERO_EN (zero denominator answered locally
// with all-ones and resp_err, divider not started).
// Ports:
//   clk, rst                         : clock, async active-high reset
//   req / req_numerator / req_denominator : per-requester request and operands
//   req_ack                          : one-cycle pulse, request consumed
//   resp_valid / resp_decimal / resp_err  : per-requester response pulse, result, error flag
//   busy                             : operation outstanding
//   dec_start / dec_numerator / dec_denominator : divider command
//   dec_done / dec_decimal           : divider completion and quotient
module calc_decimal_arbiter
    import calc_pkg::*;
#(
    parameter int unsigned P_WIDTH   = 16,
    parameter int unsigned P_NUM_REQ = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [P_NUM_REQ-1:0]          req,
    input  logic [P_NUM_REQ*P_WIDTH-1:0]  req_numerator,
    input  logic [P_NUM_REQ*P_WIDTH-1:0]  req_denominator,
    output logic [P_NUM_REQ-1:0]          req_ack,
    output logic [P_NUM_REQ-1:0]          resp_valid,
    output logic [P_WIDTH-1:0]            resp_decimal,
    output logic                          resp_err,
    output logic                          busy,
    output logic                          dec_start,
    output logic [P_WIDTH-1:0]            dec_numerator,
    output logic [P_WIDTH-1:0]            dec_denominator,
    input  logic                          dec_done,
    input  logic [P_WIDTH-1:0]            dec_decimal
);

    localparam int unsigned IW = calc_idx_width(P_NUM_REQ);

    arb_state_e             state_q;
    logic [IW-1:0]          last_grant_q;
    logic [IW-1:0]          idx_q;
    logic [P_NUM_REQ-1:0]   req_ack_q;
    logic [P_NUM_REQ-1:0]   resp_valid_q;
    logic [P_WIDTH-1:0]     resp_decimal_q;
    logic                   busy_q;
    logic                   dec_start_q;
    logic [P_WIDTH-1:0]     dec_numerator_q;
    logic [P_WIDTH-1:0]     dec_denominator_q;

    logic                   pick_valid;
    logic [IW-1:0]          pick_idx;
    logic [P_WIDTH-1:0]     pick_num;
    logic [P_WIDTH-1:0]     pick_den;

    rr_pick #(
        .P_NUM_REQ(P_NUM_REQ)
    ) u_rr_pick (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .grant_valid_o(pick_valid),
        .grant_idx_o  (pick_idx)
    );

    // Operand slice of the picked requester.
    always_comb begin
        pick_num = '0;
        pick_den = '0;
        for (int unsigned i = 0; i < P_NUM_REQ; i++) begin
            if (IW'(i) == pick_idx) begin
                pick_num = req_numerator[i*P_WIDTH +: P_WIDTH];
                pick_den = req_denominator[i*P_WIDTH +: P_WIDTH];
            end
        end
    end

`ifdef CALC_ARB_DIVZERO_EN
    logic resp_err_q;
`endif

    // Arbiter FSM; req is only looked at in IDLE so an acked level cannot re-grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= IDLE;
            // Last grant parked on the top index so the first scan starts at 0.
            last_grant_q      <= IW'(P_NUM_REQ - 1);
            idx_q             <= '0;
            req_ack_q         <= '0;
            resp_valid_q      <= '0;
            resp_decimal_q    <= '0;
            busy_q            <= 1'b0;
            dec_start_q       <= 1'b0;
            dec_numerator_q   <= '0;
            dec_denominator_q <= '0;
`ifdef CALC_ARB_DIVZERO_EN
            resp_err_q        <= 1'b0;
`endif
        end else begin
            req_ack_q    <= '0;
            resp_valid_q <= '0;
            dec_start_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        dec_numerator_q   <= pick_num;
                        dec_denominator_q <= pick_den;
                        idx_q             <= pick_idx;
                        last_grant_q      <= pick_idx;
                        req_ack_q         <= P_NUM_REQ'(1) << pick_idx;
                        busy_q            <= 1'b1;
`ifdef CALC_ARB_DIVZERO_EN
                        if (pick_den == '0) begin
                            state_q <= ZERO;
                        end else begin
                            state_q     <= WAIT;
                            dec_start_q <= 1'b1;
                        end
`else
                        state_q     <= WAIT;
                        dec_start_q <= 1'b1;
`endif
                    end
                end
                WAIT: begin
                    if (dec_done) begin
                        resp_decimal_q <= dec_decimal;
                        resp_valid_q   <= P_NUM_REQ'(1) << idx_q;
                        busy_q         <= 1'b0;
                        state_q        <= IDLE;
`ifdef CALC_ARB_DIVZERO_EN
                        resp_err_q     <= 1'b0;
`endif
                    end
                end
`ifdef CALC_ARB_DIVZERO_EN
                ZERO: begin
                    resp_decimal_q <= P_WIDTH'(CALC_ERR_ONES);
                    resp_err_q     <= 1'b1;
                    resp_valid_q   <= P_NUM_REQ'(1) << idx_q;
                    busy_q         <= 1'b0;
                    state_q        <= IDLE;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ack         = req_ack_q;
    assign resp_valid      = resp_valid_q;
    assign resp_decimal    = resp_decimal_q;
    assign busy            = busy_q;
    assign dec_start       = dec_start_q;
    assign dec_numerator   = dec_numerator_q;
    assign dec_denominator = dec_denominator_q;
`ifdef CALC_ARB_DIVZERO_EN
    assign resp_err        = resp_err_q;
`else
    assign resp_err        = 1'b0;
`endif

endmodule

// File: tb/tb_calc_decimal_arbiter.sv
// Directed bench for calc_decimal_arbiter with a fixed-latency divider model.
module tb_calc_decimal_arbiter;

    localparam int unsigned W   = 16;
    localparam int unsigned NR  = 4;
    localparam int          LAT = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*W-1:0]   req_numerator;
    logic [NR*W-1:0]   req_denominator;
    logic [NR-1:0]     req_ack;
    logic [NR-1:0]     resp_valid;
    logic [W-1:0]      resp_decimal;
    logic              resp_err;
    logic              busy;
    logic              dec_start;
    logic [W-1:0]      dec_numerator;
    logic [W-1:0]      dec_denominator;
    logic              dec_done;
    logic [W-1:0]      dec_decimal;

    calc_decimal_arbiter #(.P_WIDTH(W), .P_NUM_REQ(NR)) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .req_numerator  (req_numerator),
        .req_denominator(req_denominator),
        .req_ack        (req_ack),
        .resp_valid     (resp_valid),
        .resp_decimal   (resp_decimal),
        .resp_err       (resp_err),
        .busy           (busy),
        .dec_start      (dec_start),
        .dec_numerator  (dec_numerator),
        .dec_denominator(dec_denominator),
        .dec_done       (dec_done),
        .dec_decimal    (dec_decimal)
    );

    always #5 clk = ~clk;

    // Divider model: done LAT cycles after the start edge; den 0 yields all-ones.
    logic [W-1:0] mdl_num, mdl_den, mdl_q;
    logic         mdl_done;
    int           mdl_cnt;
    logic         spur_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_cnt <= 0; mdl_done <= 1'b0; mdl_q <= '0; mdl_num <= '0; mdl_den <= '0;
        end else begin
            mdl_done <= 1'b0;
            if (dec_start) begin
                mdl_num <= dec_numerator; mdl_den <= dec_denominator; mdl_cnt <= LAT;
            end else if (mdl_cnt != 0) begin
                mdl_cnt <= mdl_cnt - 1;
                if (mdl_cnt == 1) begin
                    mdl_done <= 1'b1;
                    mdl_q <= (mdl_den == '0) ? '1 : W'({mdl_num, 16'h0} / {16'h0, mdl_den});
                end
            end
        end
    end

    assign dec_done    = mdl_done | spur_done;
    assign dec_decimal = spur_done ? 16'h1234 : mdl_q;

    // Start counter and start-while-busy monitor.
    int   start_cnt = 0;
    int   viol = 0;
    logic busy_prev = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            busy_prev = 1'b0;
        end else begin
            if (dec_start) start_cnt++;
            if (dec_start && busy_prev) viol++;
            busy_prev = busy;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int oh_idx(input logic [NR-1:0] v);
        int r = -1;
        for (int i = 0; i < NR; i++) if (v[i]) r = (r == -1) ? i : 99;
        return r;
    endfunction

    task automatic set_ops(input int idx, input logic [W-1:0] num, input logic [W-1:0] den);
        req_numerator[idx*W +: W]   = num;
        req_denominator[idx*W +: W] = den;
    endtask

    task automatic wait_ack(output int n);
        n = -1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (req_ack != '0) begin n = i; break; end
        end
    endtask

    task automatic wait_resp(output int n, output int acks);
        n = -1; acks = 0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (req_ack != '0) acks++;
            if (resp_valid != '0) begin n = i; break; end
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    int   g_idx[8], r_idx[8], ack_cyc[8], resp_cyc[8];
    logic [W-1:0] r_val[8];
    logic r_err[8];
    int   n_ack, n_resp;

    // Raise mask, drop each bit on its ack, collect grants and responses.
    task automatic run_jobs(input logic [NR-1:0] mask, input int nexp);
        int guard = 0;
        n_ack = 0; n_resp = 0;
        req = mask;
        while (n_resp < nexp && guard < 200) begin
            @(negedge clk); guard++;
            if (req_ack != '0 && n_ack < 8) begin
                g_idx[n_ack] = oh_idx(req_ack); ack_cyc[n_ack] = guard; n_ack++;
                req = req & ~req_ack;
            end
            if (resp_valid != '0 && n_resp < 8) begin
                r_idx[n_resp] = oh_idx(resp_valid); r_val[n_resp] = resp_decimal;
                r_err[n_resp] = resp_err; resp_cyc[n_resp] = guard; n_resp++;
            end
        end
        req = '0;
        check("job_count", 32'(n_resp), 32'(nexp));
    endtask

    int n, acks, s0, cnt;

    initial begin
        rst = 1'b1; req = '0; req_numerator = '0; req_denominator = '0; spur_done = 1'b0;
        @(negedge clk); @(negedge clk);
        check("rst_req_ack", 32'(req_ack), 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_resp_decimal", 32'(resp_decimal), 0);
        check("rst_resp_err", 32'(resp_err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_dec_start", 32'(dec_start), 0);
        check("rst_dec_num", 32'(dec_numerator), 0);
        check("rst_dec_den", 32'(dec_denominator), 0);
        rst = 1'b0;
        @(negedge clk);

        // Single requester 1: 1/3.
        s0 = start_cnt;
        set_ops(1, 16'd1, 16'd3);
        req = 4'b0010;
        wait_ack(n);
        check("t1_ack_lat", 32'(n), 1);
        check("t1_ack", 32'(req_ack), 32'h2);
        check("t1_start", 32'(dec_start), 1);
        check("t1_busy", 32'(busy), 1);
        check("t1_dnum", 32'(dec_numerator), 1);
        check("t1_dden", 32'(dec_denominator), 3);
        req = '0;
        wait_resp(n, acks);
        check("t1_resp_lat", 32'(n), 32'(LAT + 2));
        check("t1_resp_valid", 32'(resp_valid), 32'h2);
        check("t1_resp_val", 32'(resp_decimal), 32'h5555);
        check("t1_resp_err", 32'(resp_err), 0);
        check("t1_busy_done", 32'(busy), 0);
        check("t1_starts", 32'(start_cnt - s0), 1);
        @(negedge clk);
        check("t1_pulse_end", 32'(resp_valid), 0);
        check("t1_hold", 32'(resp_decimal), 32'h5555);

        // Spurious done while idle is ignored.
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        check("spur_valid", 32'(resp_valid), 0);
        check("spur_hold", 32'(resp_decimal), 32'h5555);
        check("spur_busy", 32'(busy), 0);

        // Requesters 0,2,3 from reset: 1/4 each, grants 0,2,3.
        do_reset();
        s0 = start_cnt;
        for (int i = 0; i < NR; i++) set_ops(i, 16'd1, 16'd4);
        run_jobs(4'b1101, 3);
        check("t3_g0", 32'(g_idx[0]), 0);
        check("t3_g1", 32'(g_idx[1]), 2);
        check("t3_g2", 32'(g_idx[2]), 3);
        check("t3_r0", 32'(r_idx[0]), 0);
        check("t3_r1", 32'(r_idx[1]), 2);
        check("t3_r2", 32'(r_idx[2]), 3);
        check("t3_v0", 32'(r_val[0]), 32'h4000);
        check("t3_v1", 32'(r_val[1]), 32'h4000);
        check("t3_v2", 32'(r_val[2]), 32'h4000);
        check("t3_starts", 32'(start_cnt - s0), 3);
        check("t3_start_busy", 32'(viol), 0);

        // Overflow passes through truncated: 3/2 -> 0x8000.
        set_ops(2, 16'd3, 16'd2);
        run_jobs(4'b0100, 1);
        check("t4_idx", 32'(r_idx[0]), 2);
        check("t4_val", 32'(r_val[0]), 32'h8000);
        check("t4_err", 32'(r_err[0]), 0);

        // Back-to-back on requester 0: next job presented right after ack.
        set_ops(0, 16'd1, 16'd2);
        req = 4'b0001;
        wait_ack(n);
        check("t5_ack1", 32'(req_ack), 32'h1);
        set_ops(0, 16'd1, 16'd4);
        wait_resp(n, acks);
        check("t5_no_regrant", 32'(acks), 0);
        check("t5_resp1_valid", 32'(resp_valid), 32'h1);
        check("t5_resp1_val", 32'(resp_decimal), 32'h8000);
        @(negedge clk);
        check("t5_ack2_nogap", 32'(req_ack), 32'h1);
        check("t5_start2", 32'(dec_start), 1);
        check("t5_dden2", 32'(dec_denominator), 4);
        req = '0;
        wait_resp(n, acks);
        check("t5_resp2_val", 32'(resp_decimal), 32'h4000);
        check("t5_start_busy", 32'(viol), 0);

        // Reset in WAIT abandons the job; pointer restarts at 0.
        set_ops(0, 16'd1, 16'd3);
        req = 4'b0001;
        wait_ack(n);
        req = '0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_busy", 32'(busy), 0);
        check("t6_ack", 32'(req_ack), 0);
        check("t6_start", 32'(dec_start), 0);
        check("t6_valid", 32'(resp_valid), 0);
        check("t6_resp_val", 32'(resp_decimal), 0);
        check("t6_dnum", 32'(dec_numerator), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (resp_valid != '0) cnt++;
        end
        check("t6_no_resp", 32'(cnt), 0);
        set_ops(0, 16'd1, 16'd4);
        set_ops(1, 16'd3, 16'd2);
        run_jobs(4'b0011, 2);
        check("t6_g0", 32'(g_idx[0]), 0);
        check("t6_r0", 32'(r_idx[0]), 0);
        check("t6_v0", 32'(r_val[0]), 32'h4000);
        check("t6_g1", 32'(g_idx[1]), 1);
        check("t6_v1", 32'(r_val[1]), 32'h8000);

        // Zero denominator on requester 2.
        s0 = start_cnt;
        set_ops(2, 16'd1, 16'd0);
        run_jobs(4'b0100, 1);
        check("t7_idx", 32'(r_idx[0]), 2);
        check("t7_val", 32'(r_val[0]), 32'hFFFF);
`ifdef CALC_ARB_DIVZERO_EN
        check("t7_err", 32'(r_err[0]), 1);
        check("t7_starts", 32'(start_cnt - s0), 0);
        check("t7_lat", 32'(resp_cyc[0] - ack_cyc[0]), 1);
`else
        check("t7_err", 32'(r_err[0]), 0);
        check("t7_starts", 32'(start_cnt - s0), 1);
        check("t7_lat", 32'(resp_cyc[0] - ack_cyc[0]), 32'(LAT + 2));
`endif
        check("t7_start_busy", 32'(viol), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
